// File: rtl/seg_hex_driver.sv
// seg_hex_driver
//   Drives DIGITS hexadecimal seven-segment digits with per-digit decimal
//   point, per-digit blink and optional leading-zero suppression. Output is
//   either static (all digits in parallel on seg_flat) or time-multiplexed
//   (one shared scan_seg bus plus one-hot scan_an). New contents arrive over
//   a valid/ready port into a shadow register and are committed to the
//   display register at a frame boundary, so a scan never shows a torn frame.
//
//   Handshake: a load transfers on any rising clk edge where
//   load_valid && load_ready. load_ready is simply "shadow empty"; once a
//   load is taken, load_ready stays low until that shadow is committed.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   load_valid      new display contents offered
//   load_ready      shadow register free
//   load_data       nibble i = digit i (digit 0 = rightmost)
//   load_dp         decimal point enable per digit
//   load_blink      blink enable per digit
//   blank_lz        suppress leading zeros (live)
//   mode            0 = static, 1 = scan (live)
//   seg_flat        static pattern, byte i = digit i
//   scan_seg        scan-mode segment bus
//   scan_an         scan-mode one-hot digit enable
//   Segment byte (logical): bit7..bit1 = a..g, bit0 = dp.

module seg_hex_driver #(
   parameter int DIGITS     = 8,
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_DIV  = 5000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic [DIGITS-1:0]     load_dp,
   input  logic [DIGITS-1:0]     load_blink,
   input  logic                  blank_lz,
   input  logic                  mode,
   output logic [8*DIGITS-1:0]   seg_flat,
   output logic [7:0]            scan_seg,
   output logic [DIGITS-1:0]     scan_an
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int BLK_W = $clog2(BLINK_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic             INV      = (ACTIVE_LOW != 0);

   function automatic logic [7:0] hex_code(input logic [3:0] n);
      case (n)
         4'h0: hex_code = 8'hFC;
         4'h1: hex_code = 8'h60;
         4'h2: hex_code = 8'hDA;
         4'h3: hex_code = 8'hF2;
         4'h4: hex_code = 8'h66;
         4'h5: hex_code = 8'hB6;
         4'h6: hex_code = 8'hBE;
         4'h7: hex_code = 8'hE0;
         4'h8: hex_code = 8'hFE;
         4'h9: hex_code = 8'hF6;
         4'hA: hex_code = 8'hEE;
         4'hB: hex_code = 8'h3E;
         4'hC: hex_code = 8'h9C;
         4'hD: hex_code = 8'h7A;
         4'hE: hex_code = 8'h9E;
         4'hF: hex_code = 8'h8E;
      endcase
   endfunction

   // Shadow (load side) and display (committed) registers
   logic [4*DIGITS-1:0] r_shadow_data;
   logic [DIGITS-1:0]   r_shadow_dp;
   logic [DIGITS-1:0]   r_shadow_blink;
   logic                r_shadow_full;
   logic [4*DIGITS-1:0] r_disp_data;
   logic [DIGITS-1:0]   r_disp_dp;
   logic [DIGITS-1:0]   r_disp_blink;

   // Scan and blink timing
   logic [DIV_W-1:0]    r_div;
   logic [IDX_W-1:0]    r_scan_idx;
   logic [BLK_W-1:0]    r_blink_cnt;
   logic                r_phase;

   // Output flops (pin polarity already applied)
   logic [8*DIGITS-1:0] r_seg_flat;
   logic [7:0]          r_scan_seg;
   logic [DIGITS-1:0]   r_scan_an;

   logic                w_tick;
   logic                w_commit_ok;
   logic [8*DIGITS-1:0] w_flat;
   logic [7:0]          w_scan_pat;
   logic [DIGITS-1:0]   w_an;

   assign load_ready = !r_shadow_full;
   assign seg_flat   = r_seg_flat;
   assign scan_seg   = r_scan_seg;
   assign scan_an    = r_scan_an;

   // Tick only exists in scan mode; in static mode the divider is parked.
   assign w_tick      = mode && (r_div == DIV_LAST);
   // Scan mode commits only on the last digit's tick so the next frame
   // starts at digit 0 with the new contents.
   assign w_commit_ok = !mode || (w_tick && (r_scan_idx == IDX_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_data  <= '0;
         r_shadow_dp    <= '0;
         r_shadow_blink <= '0;
         r_shadow_full  <= 1'b0;
         r_disp_data    <= '0;
         r_disp_dp      <= '0;
         r_disp_blink   <= '0;
      end else begin
         if (r_shadow_full && w_commit_ok) begin
            r_disp_data   <= r_shadow_data;
            r_disp_dp     <= r_shadow_dp;
            r_disp_blink  <= r_shadow_blink;
            r_shadow_full <= 1'b0;
         end else if (load_valid && !r_shadow_full) begin
            r_shadow_data  <= load_data;
            r_shadow_dp    <= load_dp;
            r_shadow_blink <= load_blink;
            r_shadow_full  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div      <= '0;
         r_scan_idx <= '0;
      end else if (!mode) begin
         r_div      <= '0;
         r_scan_idx <= '0;
      end else if (w_tick) begin
         r_div      <= '0;
         r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_blink_cnt == BLK_LAST) begin
         r_blink_cnt <= '0;
         r_phase     <= !r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Per-digit pattern. Walking from the top digit down, zero_above stays
   // set while every nibble seen so far is zero; such digits are
   // suppressed (digit 0 excepted). Blink blanking wins over everything.
   always_comb begin
      logic       zero_above;
      logic [3:0] nib;
      zero_above = 1'b1;
      nib        = 4'h0;
      w_flat     = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib        = r_disp_data[4*i +: 4];
         zero_above = zero_above && (nib == 4'h0);
         if (r_disp_blink[i] && !r_phase)
            w_flat[8*i +: 8] = 8'h00;
         else if (blank_lz && zero_above && (i != 0))
            w_flat[8*i +: 8] = {7'b0, r_disp_dp[i]};
         else
            w_flat[8*i +: 8] = hex_code(nib) | {7'b0, r_disp_dp[i]};
      end
   end

   always_comb begin
      w_an             = '0;
      w_an[r_scan_idx] = 1'b1;
      w_scan_pat       = w_flat[{r_scan_idx, 3'b000} +: 8];
   end

   // Enable and segment bus come from the same scan_idx in the same flop
   // stage, so two enables can never be active together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_flat <= {8*DIGITS{INV}};
         r_scan_seg <= {8{INV}};
         r_scan_an  <= {DIGITS{INV}};
      end else begin
         r_seg_flat <= w_flat ^ {8*DIGITS{INV}};
         r_scan_seg <= (mode ? w_scan_pat : 8'h00) ^ {8{INV}};
         r_scan_an  <= (mode ? w_an : {DIGITS{1'b0}}) ^ {DIGITS{INV}};
      end
   end

endmodule

// File: tb/tb_seg_hex_driver.sv
// tb_seg_hex_driver
//   Bench for seg_hex_driver (DIGITS=8, SCAN_DIV=4, BLINK_DIV=8,
//   ACTIVE_LOW=0). A reference model derived from the display rules
//   (hex table lookup, shift-based leading-zero test, blink phase from edge
//   count, scan digit from edge count) predicts every output each cycle.

module tb_seg_hex_driver;

   localparam int DIGITS    = 8;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;
   localparam int FRAME     = SCAN_DIV * DIGITS;

   // Clock / reset
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic        load_valid = 1'b0;
   logic [31:0] load_data  = '0;
   logic [7:0]  load_dp    = '0;
   logic [7:0]  load_blink = '0;
   logic        blank_lz   = 1'b0;
   logic        mode       = 1'b0;
   logic        load_ready;
   logic [63:0] seg_flat;
   logic [7:0]  scan_seg;
   logic [7:0]  scan_an;

   seg_hex_driver #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_dp(load_dp), .load_blink(load_blink),
      .blank_lz(blank_lz), .mode(mode),
      .seg_flat(seg_flat), .scan_seg(scan_seg), .scan_an(scan_an)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic [7:0]  hex_tab [16];
   logic [31:0] m_data, s_data;
   logic [7:0]  m_dp, s_dp, m_blink, s_blink;
   logic        m_full;
   int          edge_cnt;   // edges since reset release
   int          scan_s;     // consecutive scan-mode edges

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_flat(input logic [31:0] d, input logic [7:0] dp,
                                              input logic [7:0] bl, input logic vis, input logic lz);
      logic [63:0] f;
      logic [7:0]  b;
      f = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bl[i] && !vis)
            b = 8'h00;
         else if (lz && i != 0 && (d >> (4*i)) == 32'd0)
            b = {7'b0, dp[i]};
         else
            b = hex_tab[d[4*i +: 4]] | {7'b0, dp[i]};
         f[8*i +: 8] = b;
      end
      return f;
   endfunction

   task automatic model_reset();
      m_data = '0; m_dp = '0; m_blink = '0;
      s_data = '0; s_dp = '0; s_blink = '0;
      m_full = 1'b0; edge_cnt = 0; scan_s = 0;
   endtask

   // One clock: predict, advance, compare every output.
   task automatic step();
      logic [63:0] e_flat;
      logic [7:0]  e_an, e_seg, l_dp, l_bl;
      logic [31:0] l_data;
      logic        vis, acc, com, mode_pre;
      int          d;
      vis      = ((edge_cnt / BLINK_DIV) % 2) == 0;
      e_flat   = model_flat(m_data, m_dp, m_blink, vis, blank_lz);
      mode_pre = mode;
      e_an     = '0;
      e_seg    = '0;
      if (mode_pre) begin
         d        = (scan_s / SCAN_DIV) % DIGITS;
         e_an[d]  = 1'b1;
         e_seg    = e_flat[8*d +: 8];
      end
      acc    = load_valid && !m_full;
      com    = m_full && (!mode_pre || (scan_s % FRAME) == FRAME - 1);
      l_data = load_data; l_dp = load_dp; l_bl = load_blink;
      @(posedge clk);
      #1;
      edge_cnt++;
      scan_s = mode_pre ? scan_s + 1 : 0;
      if (com) begin
         m_data = s_data; m_dp = s_dp; m_blink = s_blink; m_full = 1'b0;
      end
      if (acc) begin
         s_data = l_data; s_dp = l_dp; s_blink = l_bl; m_full = 1'b1;
      end
      check("seg_flat", seg_flat, e_flat);
      check("scan_an", {56'b0, scan_an}, {56'b0, e_an});
      check("scan_seg", {56'b0, scan_seg}, {56'b0, e_seg});
      check("load_ready", {63'b0, load_ready}, {63'b0, !m_full});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ready(input int max);
      for (int i = 0; i < max && !load_ready; i++) step();
      check("ready_timeout", {63'b0, load_ready}, 64'd1);
   endtask

   task automatic offer(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
      load_data = d; load_dp = dp; load_blink = bl; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   // Step until the model has committed, then one more for the output flop.
   task automatic settle(input int max);
      for (int i = 0; i < max && m_full; i++) step();
      step();
   endtask

   task automatic load_settle(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
      wait_ready(2 * FRAME);
      offer(d, dp, bl);
      settle(2 * FRAME);
   endtask

   initial begin
      int blanks, lits, others_bad;
      hex_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                  8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
      model_reset();

      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_ready", {63'b0, load_ready}, 64'd1);
      check("rst_flat", seg_flat, 64'd0);
      check("rst_an", {56'b0, scan_an}, 64'd0);
      check("rst_seg", {56'b0, scan_seg}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("first_edge_flat", seg_flat, 64'hFCFCFCFCFCFCFCFC);

      // Static load: ready low for exactly one cycle, visible after N+2
      offer(32'h0123ABCD, 8'h01, 8'h00);
      check("load_ready_low", {63'b0, load_ready}, 64'd0);
      step();
      check("load_ready_back", {63'b0, load_ready}, 64'd1);
      check("flat_before_n2", seg_flat, 64'hFCFCFCFCFCFCFCFC);
      step();
      check("static_load", seg_flat, 64'hFC60DAF2EE3E9C7B);

      // Leading-zero suppression
      blank_lz = 1'b1;
      load_settle(32'h00000050, 8'h00, 8'h00);
      check("lz_50", seg_flat, 64'h000000000000B6FC);
      load_settle(32'h00000000, 8'h00, 8'h00);
      check("lz_zero", seg_flat, 64'h00000000000000FC);
      load_settle(32'h00000050, 8'h80, 8'h00);
      check("lz_dp_kept", seg_flat, 64'h010000000000B6FC);
      blank_lz = 1'b0;
      step();
      check("lz_live_off", seg_flat, 64'hFDFCFCFCFCFCB6FC);

      // Random static loads
      for (int k = 0; k < 20; k++) begin
         blank_lz = 1'($urandom_range(0, 1));
         load_settle($urandom >> $urandom_range(0, 28), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
         steps($urandom_range(0, 5));
      end

      // Blink: digit0 alternates every BLINK_DIV clocks, dp included
      blank_lz = 1'b0;
      load_settle(32'h00000005, 8'h01, 8'h01);
      blanks = 0; lits = 0; others_bad = 0;
      for (int i = 0; i < 2 * BLINK_DIV; i++) begin
         step();
         if (seg_flat[7:0] == 8'h00) blanks++;
         if (seg_flat[7:0] == 8'hB7) lits++;
         if (seg_flat[63:8] != 56'hFCFCFCFCFCFCFC) others_bad++;
      end
      check("blink_blank_cnt", 64'(blanks), 64'(BLINK_DIV));
      check("blink_lit_cnt", 64'(lits), 64'(BLINK_DIV));
      check("blink_others", 64'(others_bad), 64'd0);

      // Scan mode: walk, then a mid-frame load committed at frame end
      load_settle(32'h76543210, 8'h00, 8'h00);
      mode = 1'b1;
      step();
      check("scan_first_an", {56'b0, scan_an}, 64'h01);
      check("scan_first_seg", {56'b0, scan_seg}, 64'hFC);
      steps(SCAN_DIV);
      check("scan_second_an", {56'b0, scan_an}, 64'h02);
      steps(FRAME + 3);
      offer(32'hFEDCBA98, 8'h10, 8'h00);
      wait_ready(2 * FRAME);
      steps(FRAME + 5);
      for (int k = 0; k < 4; k++) begin
         blank_lz = 1'($urandom_range(0, 1));
         wait_ready(2 * FRAME);
         offer($urandom >> $urandom_range(0, 28), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
         steps($urandom_range(FRAME, 2 * FRAME));
      end

      // Async reset with shadow full in scan mode
      blank_lz = 1'b0;
      wait_ready(2 * FRAME);
      steps(5);
      offer(32'h11111111, 8'hFF, 8'h00);
      check("pend_ready_low", {63'b0, load_ready}, 64'd0);
      #2 rst = 1'b1;
      #1;
      check("arst_flat", seg_flat, 64'd0);
      check("arst_an", {56'b0, scan_an}, 64'd0);
      check("arst_seg", {56'b0, scan_seg}, 64'd0);
      check("arst_ready", {63'b0, load_ready}, 64'd1);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("post_rst_an", {56'b0, scan_an}, 64'h01);
      steps(2 * FRAME);
      check("pending_lost", seg_flat, 64'hFCFCFCFCFCFCFCFC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
